// File: rtl/tft_spi_byte_receiver_pkg.sv
// Shared constants and types for the TFT SPI byte receiver.
package tft_spi_byte_receiver_pkg;

  localparam int   TFT_BYTE_W = 8;
  localparam int   TFT_WORD_W = 9;
  localparam int   TFT_DC_BIT = 8;
  localparam logic TFT_CMD    = 1'b0;
  localparam logic TFT_DATA   = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

  function automatic logic [TFT_WORD_W-1:0] tft_pack(input logic dc,
                                                     input logic [TFT_BYTE_W-1:0] b);
    return {dc, b};
  endfunction

endpackage

// File: rtl/tft_spi_byte_receiver_if.sv
// Receive-side stream: {DC, byte} words with a valid/ready handshake.
interface tft_spi_byte_receiver_if
  import tft_spi_byte_receiver_pkg::*;
  ();

  logic [TFT_WORD_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (output rx_data, output rx_valid, input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, output rx_ready);

endinterface

// File: rtl/tft_spi_byte_receiver_fifo.sv
// Show-ahead receive FIFO; a push into a full FIFO is dropped unless a pop coincides.
module tft_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tft_spi_byte_receiver.sv
// SPI mode-0 byte receiver for a TFT command/data link, oversampled on spiClk.
module tft_spi_byte_receiver
  import tft_spi_byte_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       spiClk,
  input  logic                       reset_n,
  input  logic                       tft_sck,
  input  logic                       tft_sdi,
  input  logic                       tft_dc,
  input  logic                       tft_cs,
  tft_spi_byte_receiver_if.master    rx,
  output logic                       frame_err,
  output logic                       overflow,
  output logic                       busy
);

  logic [1:0] sck_s, sdi_s, dc_s, cs_s;
  logic       sync_sck, sync_sdi, sync_dc, sync_cs;
  logic       sck_prev;
  logic       sck_rise;
  logic [1:0] live_sr;
  logic       cs_armed;
  logic       cs_fall;

  rx_state_t             state, state_nx;
  logic [2:0]            cnt, cnt_nx;
  logic [TFT_BYTE_W-1:0] shreg, shreg_nx;
  logic                  push_req, push_nx;
  logic [TFT_WORD_W-1:0] push_word, word_nx;
  logic                  ferr_nx;
  logic                  fifo_full, fifo_empty, pop;

  assign sync_sck = sck_s[1];
  assign sync_sdi = sdi_s[1];
  assign sync_dc  = dc_s[1];
  assign sync_cs  = cs_s[1];

  always_ff @(posedge spiClk or negedge reset_n) begin
    if (!reset_n) begin
      sck_s    <= '0;
      sdi_s    <= '0;
      dc_s     <= '0;
      cs_s     <= '1;
      sck_prev <= 1'b0;
      live_sr  <= '0;
      cs_armed <= 1'b0;
    end else begin
      sck_s    <= {sck_s[0], tft_sck};
      sdi_s    <= {sdi_s[0], tft_sdi};
      dc_s     <= {dc_s[0],  tft_dc};
      cs_s     <= {cs_s[0],  tft_cs};
      sck_prev <= sync_sck;
      live_sr  <= {live_sr[0], 1'b1};
      // Only arm once the synchroniser holds real samples, so a CS already
      // low at reset release is not mistaken for a fresh falling edge.
      cs_armed <= live_sr[1] && sync_cs;
    end
  end

  assign sck_rise = sync_sck && !sck_prev;
  assign cs_fall  = cs_armed && !sync_cs;

  always_ff @(posedge spiClk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      push_req  <= 1'b0;
      push_word <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      shreg     <= shreg_nx;
      push_req  <= push_nx;
      push_word <= word_nx;
      frame_err <= ferr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    push_nx  = 1'b0;
    word_nx  = push_word;
    ferr_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (cs_fall) state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sync_cs) begin
          state_nx = ST_IDLE;
          ferr_nx  = (cnt != '0);
          cnt_nx   = '0;
        end else if (sck_rise) begin
          shreg_nx = {shreg[TFT_BYTE_W-2:0], sync_sdi};
          cnt_nx   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            push_nx = 1'b1;
            word_nx = tft_pack(sync_dc, {shreg[TFT_BYTE_W-2:0], sync_sdi});
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy        = (state == ST_SHIFT);
  assign rx.rx_valid = !fifo_empty;
  assign pop         = rx.rx_valid && rx.rx_ready;

  always_ff @(posedge spiClk or negedge reset_n) begin
    if (!reset_n)                           overflow <= 1'b0;
    else if (push_req && fifo_full && !pop) overflow <= 1'b1;
  end

  tft_rx_fifo #(
    .WIDTH (TFT_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (spiClk),
    .rst_n (reset_n),
    .push  (push_req),
    .din   (push_word),
    .pop   (pop),
    .dout  (rx.rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_tft_spi_byte_receiver.sv
// Bench for tft_spi_byte_receiver: vector table, directed corner cases, randomized frames.
module tb_tft_spi_byte_receiver;

  localparam int DEPTH = 4;

  logic spiClk = 1'b0;
  logic reset_n, tft_sck, tft_sdi, tft_dc, tft_cs;
  logic frame_err, overflow, busy;

  tft_spi_byte_receiver_if rxif ();

  tft_spi_byte_receiver #(.FIFO_DEPTH(DEPTH)) dut (
    .spiClk    (spiClk),
    .reset_n   (reset_n),
    .tft_sck   (tft_sck),
    .tft_sdi   (tft_sdi),
    .tft_dc    (tft_dc),
    .tft_cs    (tft_cs),
    .rx        (rxif),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 spiClk = ~spiClk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: expected FIFO contents and flags.
  logic [8:0] exp_q[$];
  logic       exp_ovf    = 1'b0;
  int         exp_ferr   = 0;
  int         ferr_seen  = 0;
  int         pops       = 0;
  bit         frame_open = 1'b0;
  int         pend_bits  = 0;
  bit         auto_ready = 1'b0;
  logic       man_ready  = 1'b0;

  typedef struct {
    logic       dc;
    logic [7:0] b;
    int         nbits;
    logic [8:0] exp_word;
    int         exp_ferr;
    bit         close;
  } vec_t;

  vec_t vec[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Consumer side: drives rx_ready and scores every pop against the model queue.
  task automatic monitor();
    logic r;
    r = auto_ready ? 1'($urandom_range(0, 1)) : man_ready;
    rxif.rx_ready = r;
    if (frame_err) ferr_seen++;
    if (rxif.rx_valid && r) begin
      pops++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0h, expected no entry", rxif.rx_data);
      end else begin
        check("pop_data", 32'(rxif.rx_data), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge spiClk);
      monitor();
      @(posedge spiClk);
    end
    #1;
  endtask

  task automatic model_byte(input logic [8:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else                      exp_ovf = 1'b1;
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic dc, input int nbits,
                          input bit pop_at_end, output logic v3);
    tft_dc = dc;
    for (int i = 0; i < nbits; i++) begin
      tft_sck = 1'b0;
      tft_sdi = b[7-i];
      tick(4);
      tft_sck = 1'b1;
      if (i < nbits - 1) tick(4);
    end
    tick(3);
    v3 = rxif.rx_valid;
    if (pop_at_end) man_ready = 1'b1;
    tick(1);
    if (pop_at_end) man_ready = 1'b0;
    if (frame_open) begin
      if (nbits == 8 && pend_bits == 0) model_byte({dc, b});
      else pend_bits = (pend_bits + nbits) % 8;
    end
  endtask

  task automatic cs_low();
    tft_cs = 1'b0;
    tick(6);
    frame_open = 1'b1;
  endtask

  task automatic cs_high();
    tft_sck = 1'b0;
    tick(4);
    tft_cs = 1'b1;
    tick(8);
    if (frame_open && pend_bits != 0) exp_ferr++;
    frame_open = 1'b0;
    pend_bits  = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    exp_q.delete();
    exp_ovf    = 1'b0;
    frame_open = 1'b0;
    pend_bits  = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic v3;
    int   f0, p0, nb;

    vec[0] = '{dc:1'b0, b:8'h2A, nbits:8, exp_word:9'h02A, exp_ferr:0, close:1'b0};
    vec[1] = '{dc:1'b1, b:8'h00, nbits:8, exp_word:9'h100, exp_ferr:0, close:1'b0};
    vec[2] = '{dc:1'b1, b:8'hEF, nbits:8, exp_word:9'h1EF, exp_ferr:0, close:1'b1};
    vec[3] = '{dc:1'b0, b:8'hA5, nbits:5, exp_word:9'h000, exp_ferr:1, close:1'b1};
    vec[4] = '{dc:1'b1, b:8'h3C, nbits:8, exp_word:9'h13C, exp_ferr:0, close:1'b1};
    vec[5] = '{dc:1'b0, b:8'hFF, nbits:8, exp_word:9'h0FF, exp_ferr:0, close:1'b1};
    vec[6] = '{dc:1'b1, b:8'h81, nbits:7, exp_word:9'h000, exp_ferr:1, close:1'b1};

    rxif.rx_ready = 1'b0;
    tft_sck = 1'b0; tft_sdi = 1'b0; tft_dc = 1'b0; tft_cs = 1'b1;
    reset_n = 1'b0;
    #1;
    tick(2);
    check("reset_outputs", {rxif.rx_valid, rxif.rx_data, frame_err, overflow, busy}, 32'h0);
    reset_n = 1'b1;
    tick(4);

    // Vector table: single-frame cmd/data sequence, aborted byte, recovery.
    man_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      f0 = ferr_seen;
      if (!frame_open) begin
        cs_low();
        check("busy_in_frame", busy, 1'b1);
      end
      spi_byte(vec[i].b, vec[i].dc, vec[i].nbits, 1'b0, v3);
      if (vec[i].nbits == 8) begin
        check("valid_before_4cyc", v3, 1'b0);
        check("valid_at_4cyc", rxif.rx_valid, 1'b1);
        check("vec_word", 32'(rxif.rx_data), 32'(vec[i].exp_word));
      end else begin
        check("vec_no_push", rxif.rx_valid, 1'b0);
      end
      if (vec[i].close) begin
        cs_high();
        check("vec_frame_err", ferr_seen - f0, vec[i].exp_ferr);
        check("busy_after_frame", busy, 1'b0);
      end
    end
    tick(4);
    check("table_drained", exp_q.size(), 0);

    // SCK activity with CS high must be ignored.
    f0 = ferr_seen;
    spi_byte(8'hA5, 1'b1, 8, 1'b0, v3);
    spi_byte(8'h5A, 1'b0, 8, 1'b0, v3);
    tft_sck = 1'b0;
    tick(6);
    check("cs_high_no_valid", rxif.rx_valid, 1'b0);
    check("cs_high_no_ferr", ferr_seen - f0, 0);
    check("cs_high_not_busy", busy, 1'b0);

    // Overflow: 5 bytes with the consumer stalled.
    do_reset();
    man_ready = 1'b0;
    cs_low();
    for (int i = 0; i < 5; i++) spi_byte(8'($urandom), 1'($urandom), 8, 1'b0, v3);
    check("ovf_flag", overflow, exp_ovf);
    check("ovf_model_flag", exp_ovf, 1'b1);
    check("ovf_head_hold", 32'(rxif.rx_data), 32'(exp_q[0]));
    cs_high();
    p0 = pops;
    man_ready = 1'b1;
    tick(10);
    check("ovf_pop_count", pops - p0, 4);
    check("ovf_empty", rxif.rx_valid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);
    do_reset();
    check("ovf_cleared_by_reset", overflow, 1'b0);

    // Full FIFO with a pop coinciding with the next push.
    man_ready = 1'b0;
    cs_low();
    for (int i = 0; i < 4; i++) spi_byte(8'($urandom), 1'($urandom), 8, 1'b0, v3);
    spi_byte(8'hC6, 1'b1, 8, 1'b1, v3);
    check("full_pop_no_ovf", overflow, 1'b0);
    check("full_pop_valid", rxif.rx_valid, 1'b1);
    cs_high();
    p0 = pops;
    man_ready = 1'b1;
    tick(10);
    check("full_pop_count", pops - p0, 4);
    check("full_pop_empty", rxif.rx_valid, 1'b0);

    // Randomized frames with a randomly stalling consumer.
    auto_ready = 1'b1;
    for (int f = 0; f < 25; f++) begin
      cs_low();
      check("rand_busy", busy, 1'b1);
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) spi_byte(8'($urandom), 1'($urandom), 8, 1'b0, v3);
      if ($urandom_range(0, 2) == 0)
        spi_byte(8'($urandom), 1'($urandom), $urandom_range(1, 7), 1'b0, v3);
      cs_high();
      check("rand_ferr_total", ferr_seen, exp_ferr);
    end
    tick(20);
    check("rand_drained", exp_q.size(), 0);
    check("rand_no_ovf", overflow, exp_ovf);
    auto_ready = 1'b0;
    man_ready  = 1'b1;

    // Reset mid-byte, then a CS already low must not start reception.
    f0 = ferr_seen;
    cs_low();
    spi_byte(8'hC3, 1'b1, 3, 1'b0, v3);
    reset_n = 1'b0;
    tick(1);
    check("midbyte_reset_outputs", {rxif.rx_valid, rxif.rx_data, frame_err, overflow, busy}, 32'h0);
    tick(1);
    reset_n = 1'b1;
    exp_q.delete();
    frame_open = 1'b0;
    pend_bits  = 0;
    tick(4);
    spi_byte(8'h77, 1'b0, 8, 1'b0, v3);
    check("stale_cs_no_valid", rxif.rx_valid, 1'b0);
    check("stale_cs_not_busy", busy, 1'b0);
    cs_high();
    check("midbyte_no_ferr", ferr_seen - f0, 0);
    cs_low();
    spi_byte(8'h55, 1'b1, 8, 1'b0, v3);
    check("after_reset_valid", rxif.rx_valid, 1'b1);
    check("after_reset_word", 32'(rxif.rx_data), 32'h155);
    cs_high();
    tick(4);
    check("final_drained", exp_q.size(), 0);
    check("final_ferr_total", ferr_seen, exp_ferr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
